// File: rtl/instr_fetch_unit_if.sv
// Fetch unit bus bundle: instruction-memory request/response, EX redirect and IF/ID handoff.
// master = fetch unit side, slave = memory / pipeline side.
interface instr_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic        id_ready;

    modport master (
        output imem_req, imem_addr, id_valid, id_pc, id_instr,
        input  imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, id_ready
    );

    modport slave (
        input  imem_req, imem_addr, id_valid, id_pc, id_instr,
        output imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, id_ready
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: sequential PC fetch into a DEPTH-entry queue with redirect flush.
// Optional FETCH_PERF_EN adds empty-cycle and redirect counters.
module instr_fetch_unit #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 reset,
    instr_fetch_unit_if.master   bus
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]          perf_empty_cycles,
    output logic [31:0]          perf_redirects
`endif
);
    localparam int          AW  = $clog2(DEPTH);
    localparam int          CW  = $clog2(DEPTH) + 1;
    localparam int          SW  = CW + 2;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    entry_t [DEPTH-1:0] q;
    logic [AW-1:0]      wptr, rptr;
    logic [CW-1:0]      occ, outst, disc;
    logic [31:0]        fpc, resp_pc;
    logic [SW-1:0]      inflight;
    logic               hs, push, drop, pop;

    // Every slot that may eventually land in the queue is reserved before issuing.
    assign inflight      = SW'(occ) + SW'(outst) + SW'(disc);
    assign bus.imem_req  = reset && !bus.redirect && (inflight < SW'(DEPTH));
    assign bus.imem_addr = fpc;

    assign hs   = bus.imem_req && bus.imem_gnt;
    assign push = bus.imem_rvalid && (disc == '0) && !bus.redirect;
    assign drop = bus.imem_rvalid && (disc != '0) && !bus.redirect;
    assign pop  = bus.id_valid && bus.id_ready && !bus.redirect;

    assign bus.id_valid = (occ != '0);
    assign bus.id_pc    = bus.id_valid ? q[rptr].pc    : 32'h0;
    assign bus.id_instr = bus.id_valid ? q[rptr].instr : NOP;

    always_ff @(posedge clk) begin
        if (!reset) begin
            fpc     <= RESET_PC;
            resp_pc <= RESET_PC;
            wptr    <= '0;
            rptr    <= '0;
            occ     <= '0;
            outst   <= '0;
            disc    <= '0;
        end else if (bus.redirect) begin
            // Requests already issued become discards; a response this cycle retires one of them.
            fpc     <= bus.redirect_pc;
            resp_pc <= bus.redirect_pc;
            wptr    <= '0;
            rptr    <= '0;
            occ     <= '0;
            outst   <= '0;
            disc    <= disc + outst - CW'(bus.imem_rvalid);
        end else begin
            if (hs)
                fpc <= fpc + 32'd4;
            if (push) begin
                wptr    <= wptr + AW'(1);
                resp_pc <= resp_pc + 32'd4;
            end
            if (pop)
                rptr <= rptr + AW'(1);
            if (drop)
                disc <= disc - CW'(1);
            occ   <= occ + CW'(push) - CW'(pop);
            outst <= outst + CW'(hs) - CW'(push);
        end
    end

    // Queue storage carries data only; validity lives in occ.
    always_ff @(posedge clk) begin
        if (reset && push)
            q[wptr] <= '{pc: resp_pc, instr: bus.imem_rdata};
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            perf_empty_cycles <= '0;
            perf_redirects    <= '0;
        end else if (bus.redirect) begin
            perf_redirects <= perf_redirects + 32'd1;
        end else if (!bus.id_valid) begin
            perf_empty_cycles <= perf_empty_cycles + 32'd1;
        end
    end
`endif
endmodule
